// File: rtl/j0_mem_arbiter.sv
// Arbiter sharing one single-port synchronous RAM between the j0 core bus and a host port.
// Optional J0_ARB_HOST_PRIO_EN: host wins every tie instead of round-robin.
module j0_mem_arbiter #(
  parameter int AW = 15,
  parameter int DW = 16
) (
  input  logic          sys_clk_i,
  input  logic          sys_rst_n_i,
  input  logic          core_rd_i,
  input  logic          core_wr_i,
  input  logic [15:0]   core_addr_i,
  input  logic [DW-1:0] core_wdata_i,
  output logic [DW-1:0] core_rdata_o,
  output logic          core_pause_o,
  input  logic          host_req_i,
  input  logic          host_wr_i,
  input  logic [AW-1:0] host_addr_i,
  input  logic [DW-1:0] host_wdata_i,
  output logic          host_ack_o,
  output logic [DW-1:0] host_rdata_o,
  output logic [AW-1:0] ram_addr_o,
  output logic          ram_we_o,
  output logic [DW-1:0] ram_wdata_o,
  input  logic [DW-1:0] ram_rdata_i
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CRD  = 2'd1;
  localparam logic [1:0] S_HACK = 2'd2;

  logic [1:0] state, state_nxt;
  logic       last_host;
  logic       ack_q, ack_rd_q;
  logic       core_req, idle, grant_core, grant_host;

  assign core_req = core_rd_i | core_wr_i;
  assign idle     = (state == S_IDLE);

`ifdef J0_ARB_HOST_PRIO_EN
  assign grant_core = idle & core_req & ~host_req_i;
`else
  // On a tie the requester that did not win last time gets the port.
  assign grant_core = idle & core_req & (~host_req_i | last_host);
`endif
  assign grant_host = idle & host_req_i & ~grant_core;

  // A core cycle with both strobes set is treated as a write.
  always_comb begin
    state_nxt = S_IDLE;
    if (grant_host)                   state_nxt = S_HACK;
    else if (grant_core & ~core_wr_i) state_nxt = S_CRD;
  end

  assign ram_addr_o  = grant_host ? host_addr_i  : core_addr_i[AW-1:0];
  assign ram_wdata_o = grant_host ? host_wdata_i : core_wdata_i;
  assign ram_we_o    = sys_rst_n_i & ((grant_core & core_wr_i) | (grant_host & host_wr_i));

  always_comb begin
    core_pause_o = 1'b0;
    if (sys_rst_n_i) begin
      case (state)
        S_IDLE:  core_pause_o = core_req & ~(grant_core & core_wr_i);
        S_HACK:  core_pause_o = core_req;
        default: core_pause_o = 1'b0;
      endcase
    end
  end

  assign core_rdata_o = (sys_rst_n_i && state == S_CRD) ? ram_rdata_i : '0;
  assign host_ack_o   = ack_q;
  assign host_rdata_o = (sys_rst_n_i & ack_q & ack_rd_q) ? ram_rdata_i : '0;

  always_ff @(posedge sys_clk_i) begin
    if (!sys_rst_n_i) begin
      state     <= S_IDLE;
      last_host <= 1'b1;
      ack_q     <= 1'b0;
      ack_rd_q  <= 1'b0;
    end else begin
      state    <= state_nxt;
      ack_q    <= grant_host;
      ack_rd_q <= grant_host & ~host_wr_i;
      if (grant_core)      last_host <= 1'b0;
      else if (grant_host) last_host <= 1'b1;
    end
  end

endmodule

// File: tb/tb_j0_mem_arbiter.sv
// Directed bench for j0_mem_arbiter with a behavioural 1-cycle-latency RAM.
module tb_j0_mem_arbiter;
  localparam int AW = 15;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          core_rd, core_wr;
  logic [15:0]   core_addr, core_wdata, core_rdata;
  logic          core_pause;
  logic          host_req, host_wr;
  logic [AW-1:0] host_addr;
  logic [15:0]   host_wdata, host_rdata;
  logic          host_ack;
  logic [AW-1:0] ram_addr;
  logic          ram_we;
  logic [15:0]   ram_wdata, ram_rdata;

  logic [15:0] mem [0:(1<<AW)-1];
  int vecs = 0;
  int errs = 0;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (ram_we) mem[ram_addr] <= ram_wdata;
    ram_rdata <= mem[ram_addr];
  end

  j0_mem_arbiter #(.AW(AW), .DW(16)) dut (
    .sys_clk_i(clk), .sys_rst_n_i(rst_n),
    .core_rd_i(core_rd), .core_wr_i(core_wr), .core_addr_i(core_addr),
    .core_wdata_i(core_wdata), .core_rdata_o(core_rdata), .core_pause_o(core_pause),
    .host_req_i(host_req), .host_wr_i(host_wr), .host_addr_i(host_addr),
    .host_wdata_i(host_wdata), .host_ack_o(host_ack), .host_rdata_o(host_rdata),
    .ram_addr_o(ram_addr), .ram_we_o(ram_we), .ram_wdata_o(ram_wdata),
    .ram_rdata_i(ram_rdata)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vecs++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // inputs change 1 time unit after the edge, outputs are sampled mid-cycle
  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  task automatic do_reset(input int n);
    rst_n = 1'b0;
    repeat (n) step();
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0; core_rd = 1'b1; core_wr = 1'b0; core_addr = '0; core_wdata = '0;
    host_req = 1'b0; host_wr = 1'b0; host_addr = '0; host_wdata = '0;
    step();

    // reset held 3 cycles with a core read pending
    repeat (3) begin
      mid();
      chk("rst_pause", core_pause, 0);
      chk("rst_we",    ram_we,     0);
      chk("rst_ack",   host_ack,   0);
      chk("rst_crd",   core_rdata, 0);
      step();
    end
    rst_n = 1'b1; core_rd = 1'b0;
    step();

    // core write 0x0010 <= BEEF, done in one cycle
    core_wr = 1'b1; core_addr = 16'h0010; core_wdata = 16'hBEEF;
    mid();
    chk("cw_we",    ram_we,     1);
    chk("cw_pause", core_pause, 0);
    chk("cw_addr",  ram_addr,   15'h0010);
    chk("cw_data",  ram_wdata,  16'hBEEF);
    step(); core_wr = 1'b0;

    // core read 0x0010: one paused cycle, then data
    core_rd = 1'b1;
    mid();
    chk("cr_pause1", core_pause, 1);
    chk("cr_addr",   ram_addr,   15'h0010);
    chk("cr_we",     ram_we,     0);
    step();
    mid();
    chk("cr_pause2", core_pause, 0);
    chk("cr_data",   core_rdata, 16'hBEEF);
    step(); core_rd = 1'b0;

    // host write 0x0020 <= 1234
    host_req = 1'b1; host_wr = 1'b1; host_addr = 15'h0020; host_wdata = 16'h1234;
    mid();
    chk("hw_we",   ram_we,   1);
    chk("hw_addr", ram_addr, 15'h0020);
    chk("hw_ack0", host_ack, 0);
    step();
    mid();
    chk("hw_ack1", host_ack, 1);
    chk("hw_idle", ram_we,   0);
    step(); host_req = 1'b0;

    // host read 0x0020
    step();
    host_req = 1'b1; host_wr = 1'b0;
    mid();
    chk("hr_we",   ram_we,   0);
    chk("hr_ack0", host_ack, 0);
    step();
    mid();
    chk("hr_ack1", host_ack,   1);
    chk("hr_data", host_rdata, 16'h1234);
    step(); host_req = 1'b0;
    mid();
    chk("hr_ack_pulse", host_ack, 0);
    step();

`ifndef J0_ARB_HOST_PRIO_EN
    // tie after reset: core read served first, host ack in cycle 4
    do_reset(1);
    core_rd = 1'b1; core_addr = 16'h0010;
    host_req = 1'b1; host_wr = 1'b0; host_addr = 15'h0020;
    mid();
    chk("tie_c1_pause", core_pause, 1);
    chk("tie_c1_addr",  ram_addr,   15'h0010);
    chk("tie_c1_ack",   host_ack,   0);
    step();
    mid();
    chk("tie_c2_pause", core_pause, 0);
    chk("tie_c2_data",  core_rdata, 16'hBEEF);
    chk("tie_c2_ack",   host_ack,   0);
    step(); core_rd = 1'b0;
    mid();
    chk("tie_c3_addr", ram_addr, 15'h0020);
    chk("tie_c3_ack",  host_ack, 0);
    step();
    mid();
    chk("tie_c4_ack",  host_ack,   1);
    chk("tie_c4_data", host_rdata, 16'h1234);
    step(); host_req = 1'b0;

    // last grant host: core write wins the tie, host read follows
    core_wr = 1'b1; core_addr = 16'h0030; core_wdata = 16'h5A5A;
    host_req = 1'b1; host_addr = 15'h0010;
    mid();
    chk("tw_we",    ram_we,     1);
    chk("tw_addr",  ram_addr,   15'h0030);
    chk("tw_pause", core_pause, 0);
    step(); core_wr = 1'b0;
    mid();
    chk("tw_haddr", ram_addr, 15'h0010);
    step();
    mid();
    chk("tw_hack",  host_ack,   1);
    chk("tw_hdata", host_rdata, 16'hBEEF);
    step(); host_req = 1'b0;

    // core write with high address bit: truncated to AW bits
    core_wr = 1'b1; core_addr = 16'h8050; core_wdata = 16'h1111;
    mid();
    chk("trunc_addr", ram_addr, 15'h0050);
    chk("trunc_we",   ram_we,   1);
    step(); core_wr = 1'b0;

    // last grant core: host write wins, core read held through HACK
    core_rd = 1'b1; core_addr = 16'h0030;
    host_req = 1'b1; host_wr = 1'b1; host_addr = 15'h0040; host_wdata = 16'h7777;
    mid();
    chk("lose_we",    ram_we,     1);
    chk("lose_addr",  ram_addr,   15'h0040);
    chk("lose_pause", core_pause, 1);
    step();
    mid();
    chk("hack_pause", core_pause, 1);
    chk("hack_ack",   host_ack,   1);
    chk("hack_we",    ram_we,     0);
    step(); host_req = 1'b0;
    mid();
    chk("held_pause", core_pause, 1);
    chk("held_addr",  ram_addr,   15'h0030);
    step();
    mid();
    chk("held_pause2", core_pause, 0);
    chk("held_data",   core_rdata, 16'h5A5A);
    step(); core_rd = 1'b0;
    mid();
    chk("quiet_pause", core_pause, 0);
`else
    // host streams 4 writes while the core waits on a read
    do_reset(1);
    core_rd = 1'b1; core_addr = 16'h0010;
    host_req = 1'b1; host_wr = 1'b1;
    for (int i = 0; i < 4; i++) begin
      host_addr = 15'(16'h0100 + i); host_wdata = 16'(16'hA000 + i);
      mid();
      chk("prio_we",    ram_we,     1);
      chk("prio_addr",  ram_addr,   15'(16'h0100 + i));
      chk("prio_pause", core_pause, 1);
      step();
      mid();
      chk("prio_ack",    host_ack,   1);
      chk("prio_pause2", core_pause, 1);
      step();
    end
    host_req = 1'b0;
    mid();
    chk("prio_cr_pause", core_pause, 1);
    chk("prio_cr_addr",  ram_addr,   15'h0010);
    step();
    mid();
    chk("prio_cr_done", core_pause, 0);
    chk("prio_cr_data", core_rdata, 16'hBEEF);
    step(); core_rd = 1'b0;
`endif

    step();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
